// File: rtl/rf_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : rf_pkg                                                |
// | Brief    : Shared defaults, address-width helper and types for   |
// |            the decode-stage register file and its scoreboard.    |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  // Address width for a register count; never narrower than one bit.
  function automatic int addr_width(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  localparam int AW_DEF   = addr_width(NREGS_DEF);
  localparam int REG_ZERO = 0;

  typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : rf_scoreboard                                         |
// | Brief    : Per-register pending-write bits. Flush beats set,     |
// |            set beats a retiring write; register 0 never busy.    |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = addr_width(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sb_set,
  input  logic [AW-1:0]    sb_addr,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic             flush,
  output logic [NREGS-1:0] busy_vec
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;
  logic [NREGS-1:0] w_busy_nxt;

  // Decode set/clear one-hots and resolve priority: flush, then set, then clear.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (sb_set) w_set[sb_addr] = 1'b1;
    if (we)     w_clr[wa]      = 1'b1;
    w_set[REG_ZERO] = 1'b0;
    if (flush) begin
      w_busy_nxt = '0;
    end else begin
      // OR-ing the set after the clear lets a new producer supersede a retiring one.
      w_busy_nxt = (r_busy & ~w_clr) | w_set;
    end
    w_busy_nxt[REG_ZERO] = 1'b0;
  end

  // Busy-bit state register, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  assign busy_vec = r_busy;

endmodule
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : reg_file_sb                                           |
// | Brief    : Multi-port register file with optional write-to-read  |
// |            bypass and a pending-write scoreboard for hazard      |
// |            detection in decode. Register 0 reads as zero.        |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module reg_file_sb
  import rf_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEF,
  parameter  int NREGS  = NREGS_DEF,
  parameter  int NREAD  = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = addr_width(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREAD*AW-1:0]   ra,
  output logic [NREAD*XLEN-1:0] rd,
  output logic [NREAD-1:0]      rbusy,
  input  logic                  we,
  input  logic [AW-1:0]         wa,
  input  logic [XLEN-1:0]       wd,
  input  logic                  sb_set,
  input  logic [AW-1:0]         sb_addr,
  input  logic                  flush,
  output logic [NREGS-1:0]      busy_vec
);

  localparam bit BYP_EN = (BYPASS != 0);

  logic [XLEN-1:0] r_regs [NREGS];

  // Register storage: async clear, writes to register 0 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (we && (wa != AW'(REG_ZERO))) begin
      r_regs[wa] <= wd;
    end
  end

  rf_scoreboard #(
    .NREGS    (NREGS)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .we       (we),
    .wa       (wa),
    .flush    (flush),
    .busy_vec (busy_vec)
  );

  // Combinational read ports; bypass is suppressed while reset is held so
  // every port reads zero during reset regardless of the write port.
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_hit;
    logic          w_zero;

    assign w_ra   = ra[k*AW +: AW];
    assign w_zero = (w_ra == AW'(REG_ZERO));
    assign w_hit  = BYP_EN && rst_n && we && (wa == w_ra);

    assign rd[k*XLEN +: XLEN] = w_zero ? '0 :
                                w_hit  ? wd : r_regs[w_ra];
    // A bypassed value is available now, so the consumer need not stall.
    assign rbusy[k] = (w_hit && !w_zero) ? 1'b0 : busy_vec[w_ra];
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_reg_file_sb                                        |
// | Brief    : Directed and model-checked bench for reg_file_sb in   |
// |            default, no-bypass and 16/8/3 configurations.         |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module tb_reg_file_sb;

  logic clk;
  logic rst_n;

  // Default (32x32, 2 ports) inputs, shared by bypass and no-bypass copies.
  logic [9:0]  ra;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic        flush;
  logic [63:0] rd,    rd_nb;
  logic [1:0]  rbusy, rbusy_nb;
  logic [31:0] bv,    bv_nb;

  // Swept configuration: XLEN=16, NREGS=8, NREAD=3.
  logic [8:0]  ra_s;
  logic        we_s;
  logic [2:0]  wa_s;
  logic [15:0] wd_s;
  logic        sb_set_s;
  logic [2:0]  sb_addr_s;
  logic        flush_s;
  logic [47:0] rd_s;
  logic [2:0]  rbusy_s;
  logic [7:0]  bv_s;

  // Reference model of the swept instance.
  logic [15:0] m_regs [8];
  logic [7:0]  m_busy;

  int n_checks = 0;
  int n_fail   = 0;

  reg_file_sb u_dut (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd), .rbusy(rbusy),
    .we(we), .wa(wa), .wd(wd), .sb_set(sb_set), .sb_addr(sb_addr),
    .flush(flush), .busy_vec(bv)
  );

  reg_file_sb #(.BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd_nb), .rbusy(rbusy_nb),
    .we(we), .wa(wa), .wd(wd), .sb_set(sb_set), .sb_addr(sb_addr),
    .flush(flush), .busy_vec(bv_nb)
  );

  reg_file_sb #(.XLEN(16), .NREGS(8), .NREAD(3), .BYPASS(1)) u_sw (
    .clk(clk), .rst_n(rst_n), .ra(ra_s), .rd(rd_s), .rbusy(rbusy_s),
    .we(we_s), .wa(wa_s), .wd(wd_s), .sb_set(sb_set_s), .sb_addr(sb_addr_s),
    .flush(flush_s), .busy_vec(bv_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_busy = '0;
  endtask

  // Advance the swept-instance model using the inputs present at the edge.
  task automatic model_edge();
    logic [7:0] nb;
    for (int r = 0; r < 8; r++) begin
      if (flush_s)                                      nb[r] = 1'b0;
      else if (sb_set_s && sb_addr_s == 3'(r) && r != 0) nb[r] = 1'b1;
      else if (we_s && wa_s == 3'(r))                   nb[r] = 1'b0;
      else                                              nb[r] = m_busy[r];
    end
    if (we_s && wa_s != 3'd0) m_regs[wa_s] = wd_s;
    m_busy = nb;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    we = 0; sb_set = 0; flush = 0;
  endtask

  task automatic check_sweep(input string tag);
    logic [47:0] e_rd;
    logic [2:0]  e_rb;
    logic [2:0]  a;
    for (int k = 0; k < 3; k++) begin
      a = ra_s[k*3 +: 3];
      if (a == 3'd0)                e_rd[k*16 +: 16] = '0;
      else if (we_s && wa_s == a)   e_rd[k*16 +: 16] = wd_s;
      else                          e_rd[k*16 +: 16] = m_regs[a];
      e_rb[k] = (we_s && wa_s == a && a != 3'd0) ? 1'b0 : m_busy[a];
    end
    chk({tag, "_rd"},    64'(rd_s),    64'(e_rd));
    chk({tag, "_rbusy"}, 64'(rbusy_s), 64'(e_rb));
    chk({tag, "_bv"},    64'(bv_s),    64'(m_busy));
  endtask

  initial begin
    rst_n = 0; ra = '0; wa = '0; wd = '0; sb_addr = '0; idle();
    ra_s = '0; we_s = 0; wa_s = '0; wd_s = '0; sb_set_s = 0; sb_addr_s = '0; flush_s = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #1;
    chk("rst_bv",    64'(bv),    64'd0);
    chk("rst_rd",    rd,         64'd0);
    chk("rst_rbusy", 64'(rbusy), 64'd0);

    // Write and read back; write to r0 is ignored.
    we = 1; wa = 5'd5; wd = 32'hDEADBEEF; step();
    idle(); ra = {5'd0, 5'd5}; #1;
    chk("wr_r5",    64'(rd[31:0]),    64'h0000_0000_DEAD_BEEF);
    chk("wr_r5_nb", 64'(rd_nb[31:0]), 64'h0000_0000_DEAD_BEEF);
    we = 1; wa = 5'd0; wd = 32'hFFFFFFFF; step();
    idle(); #1;
    chk("wr_r0", 64'(rd[63:32]), 64'd0);

    // r7 gets a value while being claimed: the set wins, so r7 is busy.
    we = 1; wa = 5'd7; wd = 32'h11111111; sb_set = 1; sb_addr = 5'd7; step();
    idle(); ra = {5'd0, 5'd7}; #1;
    chk("r7_busy",  64'(bv[7]),    64'd1);
    chk("r7_rbusy", 64'(rbusy[0]), 64'd1);
    // Same-cycle bypass: new value and not busy with bypass, old value without.
    we = 1; wa = 5'd7; wd = 32'h12345678; #1;
    chk("byp_rd",      64'(rd[31:0]),    64'h12345678);
    chk("byp_rbusy",   64'(rbusy[0]),    64'd0);
    chk("nobyp_rd",    64'(rd_nb[31:0]), 64'h11111111);
    chk("nobyp_rbusy", 64'(rbusy_nb[0]), 64'd1);
    step();
    idle(); #1;
    chk("r7_retired", 64'(bv), 64'd0);

    // Scoreboard lifecycle on r9.
    sb_set = 1; sb_addr = 5'd9; step();
    idle(); ra = {5'd0, 5'd9}; #1;
    chk("sb9_set",   64'(bv[9]),    64'd1);
    chk("sb9_rbusy", 64'(rbusy[0]), 64'd1);
    we = 1; wa = 5'd9; wd = 32'h0000_0099; step();
    idle(); #1;
    chk("sb9_clr", 64'(bv[9]), 64'd0);
    sb_set = 1; sb_addr = 5'd0; step();
    idle(); ra = '0; #1;
    chk("sb0_never",   64'(bv),    64'd0);
    chk("rbusy_r0",    64'(rbusy), 64'd0);

    // Set and retire on r3 together: set wins. Then flush beats a set.
    sb_set = 1; sb_addr = 5'd3; we = 1; wa = 5'd3; wd = 32'h3; step();
    idle(); #1;
    chk("set_beats_clr", 64'(bv), 64'h8);
    flush = 1; sb_set = 1; sb_addr = 5'd4; step();
    idle(); #1;
    chk("flush_beats_set", 64'(bv), 64'd0);

    // Asynchronous reset mid-cycle clears data and busy bits at once.
    sb_set = 1; sb_addr = 5'd12; step();
    idle(); ra = {5'd7, 5'd5}; #1;
    chk("pre_rst_rd", rd, 64'h12345678_DEADBEEF);
    chk("pre_rst_bv", 64'(bv), 64'h1000);
    #2 rst_n = 0; model_reset();
    #1;
    chk("async_rst_rd",    rd,         64'd0);
    chk("async_rst_bv",    64'(bv),    64'd0);
    chk("async_rst_rbusy", 64'(rbusy), 64'd0);
    chk("async_rst_nb_rd", rd_nb,      64'd0);
    #1 rst_n = 1;
    step();

    // Swept configuration: three ports on the same register.
    we_s = 1; wa_s = 3'd7; wd_s = 16'hA5A5; step();
    we_s = 0; ra_s = {3'd7, 3'd7, 3'd7}; #1;
    chk("sw_3port", 64'(rd_s), 64'hA5A5_A5A5_A5A5);

    // Random write/set/flush traffic against the model.
    for (int c = 0; c < 10000; c++) begin
      we_s      = 1'($urandom_range(0, 1));
      wa_s      = 3'($urandom);
      wd_s      = 16'($urandom);
      sb_set_s  = ($urandom_range(0, 2) == 0);
      sb_addr_s = 3'($urandom);
      flush_s   = ($urandom_range(0, 31) == 0);
      ra_s      = 9'($urandom);
      #1;
      check_sweep("rand");
      if (n_fail > 20) break;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
